// File: rtl/dmux16_pkg.sv
// Shared constants and helpers for the 16-bit stream demultiplexer.
// No logic, no latency; imported by the FIFO and the top level.
package dmux16_pkg;

   localparam int WORD_W    = 16;
   localparam int DEF_N     = 4;
   localparam int DEF_DEPTH = 2;
   localparam int DEF_SEL_W = 2;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/dmux16_fifo.sv
// Per-channel synchronous FIFO, WORD_W x DEPTH; head is visible the cycle after the first push.
// Caller must not push when full or pop when empty; head reads as zero while empty.
module dmux16_fifo
   import dmux16_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dmux16_stream.sv
// Steers each accepted word to channel in_sel through a per-channel FIFO; 1-cycle latency to out_valid.
// in_ready depends only on in_sel and registered FIFO state, never on out_ready; bad selects are dropped.
module dmux16_stream
   import dmux16_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WORD_W-1:0]   in_data,
   input  logic [SEL_W-1:0]    in_sel,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [WORD_W*N-1:0] out_data,
   output logic [N-1:0]        out_valid,
   input  logic [N-1:0]        out_ready,
   output logic                drop
);

   localparam int CW = $clog2(DEPTH + 1);

   logic         sel_ok;
   logic         sel_full;
   logic         accept;
   logic [N-1:0] full;
   logic [N-1:0] empty;
   logic [N-1:0] push;
   logic [N-1:0] pop;

   always_comb begin
      sel_ok   = (int'(in_sel) < N);
      sel_full = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (in_sel == SEL_W'(c)) sel_full = full[c];
      end
      in_ready = rst_n && (!sel_ok || !sel_full);
      accept   = in_valid && in_ready;
   end

   for (genvar c = 0; c < N; c++) begin : g_ch
      logic [CW-1:0] cnt;

      assign push[c]      = accept && (in_sel == SEL_W'(c));
      assign pop[c]       = out_valid[c] && out_ready[c];
      assign out_valid[c] = !empty[c];

      dmux16_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[c]),
         .pop   (pop[c]),
         .wdata (in_data),
         .head  (out_data[WORD_W*c +: WORD_W]),
         .full  (full[c]),
         .empty (empty[c]),
         .count (cnt)
      );

      a_full_cnt: assert property (@(posedge clk) disable iff (!rst_n)
                                   full[c] == (cnt == CW'(DEPTH)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) drop <= 1'b0;
      else        drop <= accept && !sel_ok;
   end

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed bench: reset, table-driven routing/backpressure vectors, then invalid-select and mid-run reset sequences.
module tb_dmux16_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic        drop;

   logic [15:0] in_data3;
   logic [1:0]  in_sel3;
   logic        in_valid3;
   logic        in_ready3;
   logic [47:0] out_data3;
   logic [2:0]  out_valid3;
   logic [2:0]  out_ready3;
   logic        drop3;

   dmux16_stream #(.N(4), .DEPTH(2), .SEL_W(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .drop      (drop)
   );

   dmux16_stream #(.N(3), .DEPTH(2), .SEL_W(2)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_sel    (in_sel3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .drop      (drop3)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        vld;
      logic [1:0]  sel;
      logic [15:0] dat;
      logic [3:0]  ordy;
      logic        e_rdy;
      logic [3:0]  e_vld;
      logic [63:0] e_dat;
   } vec_t;

   vec_t tbl [24];

   initial begin
      // vld sel data ordy | rdy vld data (state before this cycle's edge)
      tbl[0]  = '{1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0000, 64'h0};
      tbl[1]  = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0100, 64'h0000_BEEF_0000_0000};
      tbl[2]  = '{1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0100, 64'h0000_BEEF_0000_0000};
      tbl[3]  = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000, 64'h0};
      tbl[4]  = '{1'b1, 2'd1, 16'h0001, 4'b0000, 1'b1, 4'b0000, 64'h0};
      tbl[5]  = '{1'b1, 2'd1, 16'h0002, 4'b0000, 1'b1, 4'b0010, 64'h0000_0000_0001_0000};
      tbl[6]  = '{1'b1, 2'd1, 16'h0003, 4'b0000, 1'b0, 4'b0010, 64'h0000_0000_0001_0000};
      tbl[7]  = '{1'b1, 2'd1, 16'h0003, 4'b0000, 1'b0, 4'b0010, 64'h0000_0000_0001_0000};
      tbl[8]  = '{1'b1, 2'd1, 16'h0003, 4'b0010, 1'b0, 4'b0010, 64'h0000_0000_0001_0000};
      tbl[9]  = '{1'b1, 2'd1, 16'h0003, 4'b0010, 1'b1, 4'b0010, 64'h0000_0000_0002_0000};
      tbl[10] = '{1'b0, 2'd1, 16'h0000, 4'b0010, 1'b1, 4'b0010, 64'h0000_0000_0003_0000};
      tbl[11] = '{1'b0, 2'd1, 16'h0000, 4'b0000, 1'b1, 4'b0000, 64'h0};
      tbl[12] = '{1'b1, 2'd0, 16'h1111, 4'b0001, 1'b1, 4'b0000, 64'h0};
      tbl[13] = '{1'b1, 2'd0, 16'h2222, 4'b0001, 1'b1, 4'b0001, 64'h0000_0000_0000_1111};
      tbl[14] = '{1'b1, 2'd3, 16'hA000, 4'b0001, 1'b1, 4'b0001, 64'h0000_0000_0000_2222};
      tbl[15] = '{1'b1, 2'd3, 16'hA001, 4'b1000, 1'b1, 4'b1000, 64'hA000_0000_0000_0000};
      tbl[16] = '{1'b0, 2'd3, 16'h0000, 4'b0000, 1'b1, 4'b1000, 64'hA001_0000_0000_0000};
      tbl[17] = '{1'b1, 2'd3, 16'hA002, 4'b0000, 1'b1, 4'b1000, 64'hA001_0000_0000_0000};
      tbl[18] = '{1'b1, 2'd0, 16'h0BAD, 4'b0000, 1'b1, 4'b1000, 64'hA001_0000_0000_0000};
      tbl[19] = '{1'b1, 2'd3, 16'hA003, 4'b0000, 1'b0, 4'b1001, 64'hA001_0000_0000_0BAD};
      tbl[20] = '{1'b1, 2'd3, 16'hA003, 4'b1001, 1'b0, 4'b1001, 64'hA001_0000_0000_0BAD};
      tbl[21] = '{1'b0, 2'd3, 16'h0000, 4'b0000, 1'b1, 4'b1000, 64'hA002_0000_0000_0000};
      tbl[22] = '{1'b0, 2'd3, 16'h0000, 4'b1000, 1'b1, 4'b1000, 64'hA002_0000_0000_0000};
      tbl[23] = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000, 64'h0};

      rst_n      = 1'b0;
      in_valid   = 1'b1;
      in_data    = 16'hFFFF;
      in_sel     = 2'd0;
      out_ready  = 4'b0000;
      in_valid3  = 1'b0;
      in_data3   = 16'h0000;
      in_sel3    = 2'd0;
      out_ready3 = 3'b000;

      // Reset held two cycles with a word offered.
      next_cycle();
      @(negedge clk);
      check("rst in_ready", 64'(in_ready), 64'(0));
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst out_data", out_data, 64'h0);
      check("rst drop", 64'(drop), 64'(0));
      next_cycle();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post-rst in_ready", 64'(in_ready), 64'(1));
      check("post-rst out_valid", 64'(out_valid), 64'(0));
      next_cycle();
      @(negedge clk);
      check("post-rst no word", 64'(out_valid), 64'(0));
      next_cycle();

      for (int i = 0; i < 24; i++) begin
         in_valid  = tbl[i].vld;
         in_sel    = tbl[i].sel;
         in_data   = tbl[i].dat;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
         check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_vld));
         check($sformatf("v%0d out_data", i), out_data, tbl[i].e_dat);
         check($sformatf("v%0d drop", i), 64'(drop), 64'(0));
         next_cycle();
      end
      in_valid  = 1'b0;
      out_ready = 4'b0000;

      // Invalid select on the three-channel instance.
      in_valid3 = 1'b1;
      in_sel3   = 2'd0;
      in_data3  = 16'h7777;
      next_cycle();
      in_sel3  = 2'd3;
      in_data3 = 16'h1234;
      @(negedge clk);
      check("inv in_ready", 64'(in_ready3), 64'(1));
      check("inv drop before", 64'(drop3), 64'(0));
      next_cycle();
      in_valid3 = 1'b0;
      in_sel3   = 2'd0;
      @(negedge clk);
      check("inv drop pulse", 64'(drop3), 64'(1));
      check("inv out_valid", 64'(out_valid3), 64'(3'b001));
      check("inv out_data", 64'(out_data3), 64'h7777);
      next_cycle();
      @(negedge clk);
      check("inv drop clear", 64'(drop3), 64'(0));
      check("inv out_valid kept", 64'(out_valid3), 64'(3'b001));
      next_cycle();

      // Reset in the middle of operation with ch0 full.
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 16'hC0C0;
      next_cycle();
      in_data = 16'hC1C1;
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid ch0 full", 64'(out_valid), 64'(4'b0001));
      check("mid in_ready full", 64'(in_ready), 64'(0));
      next_cycle();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hDEAD;
      out_ready = 4'b0001;
      @(negedge clk);
      check("mid rst in_ready", 64'(in_ready), 64'(0));
      next_cycle();
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      @(negedge clk);
      check("mid rst out_valid", 64'(out_valid), 64'(0));
      check("mid rst out_data", out_data, 64'h0);
      check("mid rst drop", 64'(drop), 64'(0));
      check("mid rst dut3 valid", 64'(out_valid3), 64'(0));
      next_cycle();
      in_valid = 1'b1;
      in_data  = 16'h5555;
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid new valid", 64'(out_valid), 64'(4'b0001));
      check("mid new head", out_data, 64'h0000_0000_0000_5555);
      next_cycle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
